// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the freq_meter block.
package freq_meter_pkg;

    // Number of flops that bring sig_in into the clk domain.
    localparam int unsigned SYNC_DEPTH = 2;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/freq_meter_ch.sv
// One measurement channel: synchronizer, rising-edge detector, saturating
// edge counter with overflow flag and, when FREQ_METER_PERIOD_EN is defined,
// a free-running period counter.
module freq_meter_ch
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
`ifdef FREQ_METER_PERIOD_EN
    ,
    parameter int unsigned PER_W = 20
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] cnt_next,
    output logic             ovf_next
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [PER_W-1:0] period_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;
    logic                  edge_det;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ovf_q;

    // Synchronize the input and keep one more stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], sig_in};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign edge_det = sync_q[SYNC_DEPTH-1] & ~prev_q;

    // Next count: clear on window start, otherwise saturate and flag overflow.
    always_comb begin
        cnt_next = cnt_q;
        ovf_next = ovf_q;
        if (clear) begin
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (count_en && edge_det) begin
            if (cnt_q == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_q + 1'b1;
            end
        end
    end

    // Edge counter and overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next;
            ovf_q <= ovf_next;
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    logic [PER_W-1:0] per_cnt_q;
    logic [PER_W-1:0] period_q;

    // Free-running period counter; each edge captures it and restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q <= '0;
            period_q  <= '0;
        end else if (edge_det) begin
            period_q  <= per_cnt_q;
            per_cnt_q <= PER_W'(1);
        end else if (per_cnt_q != PER_MAX) begin
            per_cnt_q <= per_cnt_q + 1'b1;
        end
    end

    assign period_out = period_q;
`endif

endmodule

// File: rtl/freq_meter.sv
// Multi-channel gated frequency meter. Counts rising edges of each sig_in bit
// over a window of GATE_CYCLES clocks and latches the counts with a valid
// pulse. Optional per-channel period measurement: define FREQ_METER_PERIOD_EN.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned PER_W       = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       sig_in,
    output logic [NUM_CH*CNT_W-1:0] freq_out,
    output logic [NUM_CH-1:0]       ovf,
    output logic                    valid,
    output logic                    busy
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [NUM_CH*PER_W-1:0] period_out
`endif
);

    localparam int unsigned       GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 1 || PER_W < 1 || GATE_CYCLES < 4)
    begin : g_param_check
        $error("freq_meter: parameter out of range");
    end

    state_e              state_q, state_d;
    logic [GATE_W-1:0]   gate_q;
    logic                clear, count_en, latch;
    logic [CNT_W-1:0]    cnt_next [NUM_CH];
    logic [NUM_CH-1:0]   ovf_next;
    logic [NUM_CH*CNT_W-1:0] freq_q;
    logic [NUM_CH-1:0]   ovf_q;
    logic                valid_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        freq_meter_ch #(
            .CNT_W (CNT_W)
`ifdef FREQ_METER_PERIOD_EN
            ,
            .PER_W (PER_W)
`endif
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .sig_in   (sig_in[k]),
            .clear    (clear),
            .count_en (count_en),
            .cnt_next (cnt_next[k]),
            .ovf_next (ovf_next[k])
`ifdef FREQ_METER_PERIOD_EN
            ,
            .period_out (period_out[k*PER_W +: PER_W])
`endif
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and window control; dropping en in GATE aborts the window.
    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        count_en = 1'b0;
        latch    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = GATE;
                    clear   = 1'b1;
                end
            end
            GATE: begin
                busy     = 1'b1;
                count_en = 1'b1;
                if (!en) begin
                    state_d = IDLE;
                end else if (gate_q == GATE_LAST) begin
                    state_d = LATCH;
                    latch   = 1'b1;
                end
            end
            LATCH: begin
                if (en) begin
                    state_d = GATE;
                    clear   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate cycle counter, restarted on every window entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= '0;
        end else if (clear) begin
            gate_q <= '0;
        end else if (count_en) begin
            gate_q <= gate_q + 1'b1;
        end
    end

    // Results load from the channels' next counts so the final gate cycle is
    // included and the new values are visible while valid is high in LATCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q  <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= latch;
            if (latch) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    freq_q[k*CNT_W +: CNT_W] <= cnt_next[k];
                end
                ovf_q <= ovf_next;
            end
        end
    end

    assign freq_out = freq_q;
    assign ovf      = ovf_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (2 channels, 8-bit counts, 1000-cycle
// gate). Expected counts come from a list of driven rising edges and the
// window bounds, not from the design's internal sequencing.
module tb_freq_meter;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int GATE_CYCLES = 1000;
    localparam int PER_W       = 12;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                    clk    = 1'b0;
    logic                    rst_n  = 1'b0;
    logic                    en     = 1'b0;
    logic [NUM_CH-1:0]       sig_in = '0;
    logic [NUM_CH*CNT_W-1:0] freq_out;
    logic [NUM_CH-1:0]       ovf;
    logic                    valid;
    logic                    busy;
`ifdef FREQ_METER_PERIOD_EN
    logic [NUM_CH*PER_W-1:0] period_out;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Per-channel stimulus: square wave period (0 = off) and a one-shot pulse.
    int per_len  [NUM_CH] = '{default: 0};
    int ph       [NUM_CH] = '{default: 0};
    int pulse_at [NUM_CH] = '{default: -100};

    typedef struct {
        int ch;
        int at;
    } edge_t;
    edge_t edges[$];

    int exp_f [NUM_CH];
    int exp_o [NUM_CH];

    freq_meter #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .GATE_CYCLES (GATE_CYCLES),
        .PER_W       (PER_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sig_in   (sig_in),
        .freq_out (freq_out),
        .ovf      (ovf),
        .valid    (valid),
        .busy     (busy)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_out (period_out)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive sig_in 1 time unit after each clock and log every rising edge.
    initial begin
        logic [NUM_CH-1:0] s;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                s[c] = 1'b0;
                if (per_len[c] >= 2) begin
                    ph[c] = (ph[c] + 1 >= per_len[c]) ? 0 : ph[c] + 1;
                    s[c]  = (ph[c] < per_len[c] / 2);
                end
                if (cyc >= pulse_at[c] && cyc < pulse_at[c] + 2) s[c] = 1'b1;
                if (s[c] && !sig_in[c]) edges.push_back('{ch: c, at: cyc});
            end
            sig_in = s;
        end
    end

    // An edge driven after clock n is seen by the detector in the cycle after
    // clock n+2 (two synchronizer stages); it counts if that cycle is one of
    // the GATE_CYCLES cycles starting with the cycle after clock g0.
    function automatic int model_count(input int ch, input int g0);
        int n = 0;
        foreach (edges[i]) begin
            if (edges[i].ch == ch && edges[i].at + 2 >= g0 &&
                edges[i].at + 2 < g0 + GATE_CYCLES) n++;
        end
        return n;
    endfunction

    task automatic wait_valid(input int exp_cyc);
        int got = -1;
        for (int i = 0; i < GATE_CYCLES + 100; i++) begin
            @(negedge clk);
            if (valid) begin
                got = cyc;
                break;
            end
        end
        check_eq("valid_cycle", got, exp_cyc);
    endtask

    // Check one window whose first gate cycle follows clock g0.
    task automatic run_window(input int g0);
        int n;
        wait_valid(g0 + GATE_CYCLES);
        for (int c = 0; c < NUM_CH; c++) begin
            n = model_count(c, g0);
            exp_f[c] = (n > CNT_MAX) ? CNT_MAX : n;
            exp_o[c] = (n > CNT_MAX) ? 1 : 0;
            check_eq($sformatf("freq_ch%0d", c), int'(freq_out[c*CNT_W +: CNT_W]), exp_f[c]);
            check_eq($sformatf("ovf_ch%0d", c), int'(ovf[c]), exp_o[c]);
        end
        check_eq("busy_in_latch", int'(busy), 0);
        @(negedge clk);
        check_eq("valid_one_cycle", int'(valid), 0);
    endtask

    initial begin
        int g0;
        int nv;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_freq", int'(freq_out), 0);
        check_eq("rst_ovf", int'(ovf), 0);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Periods 10 and 40, back-to-back windows.
        per_len = '{10, 40};
        repeat (50) @(posedge clk);
        #1 en = 1'b1;
        g0 = cyc + 1;
        for (int w = 0; w < 3; w++) begin
            run_window(g0);
            g0 += GATE_CYCLES + 1;
        end

        // Random periods, some channels idle.
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                per_len[c] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, 300));
            end
            run_window(g0);
            g0 += GATE_CYCLES + 1;
        end

        // Toggle every clock on ch0: saturation.
        per_len = '{2, 40};
        run_window(g0);
        check_eq("sat_cnt_ch0", int'(freq_out[CNT_W-1:0]), CNT_MAX);
        check_eq("sat_ovf_ch0", int'(ovf[0]), 1);
        g0 += GATE_CYCLES + 1;

        // Abort mid-window by dropping en.
        do begin
            @(posedge clk);
            #1;
        end while (cyc < g0 + 500);
        en = 1'b0;
        @(negedge clk);
        check_eq("busy_before_abort", int'(busy), 1);
        @(negedge clk);
        check_eq("busy_after_abort", int'(busy), 0);
        nv = 0;
        repeat (1200) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check_eq("abort_no_valid", nv, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            check_eq($sformatf("abort_hold_ch%0d", c), int'(freq_out[c*CNT_W +: CNT_W]), exp_f[c]);
            check_eq($sformatf("abort_hold_ovf%0d", c), int'(ovf[c]), exp_o[c]);
        end

        // Reset in the middle of a window.
        @(posedge clk);
        #1 en = 1'b1;
        g0 = cyc + 1;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < g0 + 300);
        rst_n   = 1'b0;
        per_len = '{0, 0};
        #1;
        check_eq("midrst_freq", int'(freq_out), 0);
        check_eq("midrst_ovf", int'(ovf), 0);
        check_eq("midrst_valid", int'(valid), 0);
        check_eq("midrst_busy", int'(busy), 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        g0 = cyc + 1;
        per_len = '{10, 40};
        run_window(g0);
        g0 += GATE_CYCLES + 1;

        // Single edges at the window boundary.
        per_len = '{0, 0};
        run_window(g0);
        g0 += GATE_CYCLES + 1;
        pulse_at[0] = g0 + GATE_CYCLES - 3;  // detected in the last gate cycle
        pulse_at[1] = g0 + GATE_CYCLES - 2;  // detected in the LATCH cycle
        run_window(g0);
        check_eq("edge_last_gate_cycle", int'(freq_out[CNT_W-1:0]), 1);
        check_eq("edge_in_latch_this", int'(freq_out[CNT_W +: CNT_W]), 0);
        g0 += GATE_CYCLES + 1;
        run_window(g0);
        check_eq("edge_in_latch_next", int'(freq_out[CNT_W +: CNT_W]), 0);
        en = 1'b0;

`ifdef FREQ_METER_PERIOD_EN
        per_len[0] = 37;
        repeat (200) @(posedge clk);
        #1;
        check_eq("period_37", int'(period_out[PER_W-1:0]), 37);
        per_len[0] = 0;
        repeat (4300) @(posedge clk);
        #1 pulse_at[0] = cyc + 2;
        repeat (10) @(posedge clk);
        #1;
        check_eq("period_sat", int'(period_out[PER_W-1:0]), (1 << PER_W) - 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
